// File: rtl/wb_sram_pipe_if.sv
// Wishbone B4 bus bundle between a master and the wb_sram_pipe slave.
interface wb_sram_pipe_if #(
    parameter int addr_width = 32,
    parameter int data_width = 32
);
    localparam int sel_width = data_width / 8;

    logic [addr_width-1:0] wb_adr;
    logic [data_width-1:0] wb_datwr;
    logic [data_width-1:0] wb_datrd;
    logic                  wb_we;
    logic [sel_width-1:0]  wb_sel;
    logic                  wb_stb;
    logic                  wb_cyc;
    logic                  wb_ack;
    logic                  wb_err;
    logic                  wb_stall;

    modport slave (
        input  wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc,
        output wb_datrd, wb_ack, wb_err, wb_stall
    );

    modport master (
        output wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc,
        input  wb_datrd, wb_ack, wb_err, wb_stall
    );
endinterface

// File: rtl/wb_sram_pipe.sv
// Parametrised Wishbone SRAM slave with classic or B4-pipelined handshake
// and an error termination for addresses outside the memory window.
module wb_sram_pipe #(
    parameter int                    addr_width = 32,
    parameter int                    data_width = 32,
    parameter int                    sel_width  = data_width / 8,
    parameter int                    depth      = 256,
    parameter logic [addr_width-1:0] base_addr  = '0,
    parameter bit                    pipelined  = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    wb_sram_pipe_if.slave  wb
);
    localparam int lane_bits = $clog2(sel_width);
    localparam int idx_width = $clog2(depth);
    localparam logic [addr_width-1:0] depth_a = addr_width'(depth);

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_ACK,
        RESP_ERR
    } resp_t;

    resp_t                 resp_q, resp_d;
    logic [data_width-1:0] datrd_q, datrd_d;
    logic [data_width-1:0] mem [depth];

    logic [addr_width-1:0] offset;
    logic [addr_width-1:0] word_off;
    logic [idx_width-1:0]  idx;
    logic                  below;
    logic                  in_range;
    logic                  accept;
    logic                  wr_en;

    // The full-width index compare keeps index==depth from aliasing onto word 0.
    always_comb begin
        offset   = wb.wb_adr - base_addr;
        word_off = offset >> lane_bits;
        below    = wb.wb_adr < base_addr;
        in_range = !below && (word_off < depth_a);
        idx      = word_off[idx_width-1:0];
        accept   = wb.wb_cyc && wb.wb_stb && (pipelined || (resp_q == RESP_IDLE));
        wr_en    = accept && in_range && wb.wb_we && reset;
    end

    always_comb begin
        resp_d  = RESP_IDLE;
        datrd_d = datrd_q;
        if (accept) begin
            resp_d = in_range ? RESP_ACK : RESP_ERR;
            if (in_range && !wb.wb_we) begin
                datrd_d = mem[idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_q  <= RESP_IDLE;
            datrd_q <= '0;
        end else begin
            resp_q  <= resp_d;
            datrd_q <= datrd_d;
        end
    end

    // Storage is deliberately left out of reset; only the lane write is gated.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < sel_width; i++) begin
                if (wb.wb_sel[i]) begin
                    mem[idx][8*i +: 8] <= wb.wb_datwr[8*i +: 8];
                end
            end
        end
    end

    assign wb.wb_datrd = datrd_q;
    assign wb.wb_ack   = (resp_q == RESP_ACK) && wb.wb_cyc;
    assign wb.wb_err   = (resp_q == RESP_ERR) && wb.wb_cyc;
    assign wb.wb_stall = 1'b0;
endmodule

// File: tb/tb_wb_sram_pipe.sv
// Self-checking bench for wb_sram_pipe: a pipelined instance driven by directed
// and random bursts against a word-array model, plus a classic-mode instance.
module tb_wb_sram_pipe;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 256;

    typedef struct {
        logic        idle;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } req_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_datrd = '0;
    req_t        burst_q [$];

    wb_sram_pipe_if #(.addr_width(32), .data_width(32)) bus_p ();
    wb_sram_pipe_if #(.addr_width(32), .data_width(32)) bus_c ();

    wb_sram_pipe #(
        .addr_width(32), .data_width(32), .sel_width(4), .depth(DEPTH),
        .base_addr(BASE), .pipelined(1'b1)
    ) dut_p (
        .clock(clock),
        .reset(reset),
        .wb(bus_p.slave)
    );

    wb_sram_pipe #(
        .addr_width(32), .data_width(32), .sel_width(4), .depth(16),
        .base_addr(32'h0), .pipelined(1'b0)
    ) dut_c (
        .clock(clock),
        .reset(reset),
        .wb(bus_c.slave)
    );

    always #5 clock = ~clock;

    function automatic req_t mk(input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel);
        req_t r;
        r.idle = 1'b0;
        r.we   = we;
        r.adr  = adr;
        r.dat  = dat;
        r.sel  = sel;
        return r;
    endfunction

    function automatic req_t mk_idle();
        req_t r;
        r.idle = 1'b1;
        r.we   = 1'b0;
        r.adr  = '0;
        r.dat  = '0;
        r.sel  = '0;
        return r;
    endfunction

    function automatic logic [31:0] waddr(input int w);
        return BASE + 32'(4 * w);
    endfunction

    // Memory behaviour expressed as plain arithmetic on a word array.
    function automatic void model_step(input req_t r, output logic ea, output logic ee);
        int unsigned w;
        ea = 1'b0;
        ee = 1'b0;
        if (r.idle) return;
        if (r.adr < BASE || ((r.adr - BASE) / 4) >= DEPTH) begin
            ee = 1'b1;
            return;
        end
        w  = (r.adr - BASE) / 4;
        ea = 1'b1;
        if (r.we) begin
            for (int b = 0; b < 4; b++)
                if (r.sel[b]) ref_mem[w][8*b +: 8] = r.dat[8*b +: 8];
        end else begin
            exp_datrd = ref_mem[w];
        end
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic ea, input logic ee,
                                input logic [31:0] ed);
        check_eq({tag, ".ack"},   32'(bus_p.wb_ack),   32'(ea));
        check_eq({tag, ".err"},   32'(bus_p.wb_err),   32'(ee));
        check_eq({tag, ".datrd"}, bus_p.wb_datrd,      ed);
        check_eq({tag, ".stall"}, 32'(bus_p.wb_stall), 32'h0);
    endtask

    task automatic apply_stimulus(input req_t r);
        bus_p.wb_cyc   = !r.idle;
        bus_p.wb_stb   = !r.idle;
        bus_p.wb_we    = r.we;
        bus_p.wb_adr   = r.adr;
        bus_p.wb_datwr = r.dat;
        bus_p.wb_sel   = r.sel;
    endtask

    // One request per cycle; each response is checked in the cycle after its edge.
    task automatic run_burst(input string tag);
        logic ea, ee;
        for (int i = 0; i < burst_q.size(); i++) begin
            apply_stimulus(burst_q[i]);
            model_step(burst_q[i], ea, ee);
            step();
            check_output($sformatf("%s[%0d]", tag, i), ea, ee, exp_datrd);
        end
        apply_stimulus(mk_idle());
        burst_q.delete();
    endtask

    initial begin
        int w;
        req_t r;

        apply_stimulus(mk_idle());
        bus_c.wb_cyc = 1'b0; bus_c.wb_stb = 1'b0; bus_c.wb_we = 1'b0;
        bus_c.wb_adr = '0;   bus_c.wb_datwr = '0; bus_c.wb_sel = '0;

        reset = 1'b0;
        step();
        step();
        check_output("init_reset", 1'b0, 1'b0, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) burst_q.push_back(mk(1'b1, waddr(i), $urandom, 4'hF));
        for (int i = 248; i < 256; i++) burst_q.push_back(mk(1'b1, waddr(i), $urandom, 4'hF));
        run_burst("preload");

        // Pending ack is wiped by reset; the write held during reset must not land.
        apply_stimulus(mk(1'b0, waddr(1), '0, 4'h0));
        model_step(mk(1'b0, waddr(1), '0, 4'h0), r.idle, r.we);
        step();
        check_output("pre_reset_read", 1'b1, 1'b0, exp_datrd);
        reset = 1'b0;
        apply_stimulus(mk(1'b1, waddr(0), 32'hDEAD_BEEF, 4'hF));
        exp_datrd = '0;
        step();
        check_output("reset_hold1", 1'b0, 1'b0, 32'h0);
        step();
        check_output("reset_hold2", 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        apply_stimulus(mk_idle());
        step();
        check_output("reset_release", 1'b0, 1'b0, 32'h0);
        burst_q.push_back(mk(1'b0, waddr(0), '0, 4'h0));
        run_burst("reset_word0");

        burst_q.push_back(mk(1'b1, waddr(3), 32'hFFFF_FFFF, 4'hF));
        burst_q.push_back(mk(1'b1, waddr(3), 32'h1234_5678, 4'b0101));
        burst_q.push_back(mk(1'b0, waddr(3), '0, 4'h0));
        run_burst("lanes");
        check_eq("lanes_value", bus_p.wb_datrd, 32'hFF34_FF78);

        burst_q.push_back(mk(1'b1, waddr(10), 32'hA5A5_A5A5, 4'hF));
        burst_q.push_back(mk(1'b0, waddr(10), '0, 4'h0));
        burst_q.push_back(mk(1'b0, waddr(11), '0, 4'h0));
        burst_q.push_back(mk(1'b1, waddr(11), 32'h0BAD_F00D, 4'hF));
        burst_q.push_back(mk(1'b0, waddr(11), '0, 4'h0));
        run_burst("b2b");

        burst_q.push_back(mk(1'b0, 32'h0000_13FC, '0, 4'h0));
        burst_q.push_back(mk(1'b0, 32'h0000_1400, '0, 4'h0));
        burst_q.push_back(mk(1'b1, 32'h0000_0FFC, 32'h5555_AAAA, 4'hF));
        burst_q.push_back(mk(1'b0, waddr(255), '0, 4'h0));
        burst_q.push_back(mk(1'b0, waddr(0), '0, 4'h0));
        run_burst("range");

        apply_stimulus(mk(1'b0, waddr(5), '0, 4'h0));
        model_step(mk(1'b0, waddr(5), '0, 4'h0), r.idle, r.we);
        step();
        bus_p.wb_cyc = 1'b0;
        bus_p.wb_stb = 1'b0;
        #1;
        check_output("abort_drop", 1'b0, 1'b0, exp_datrd);
        step();
        check_output("abort_after", 1'b0, 1'b0, exp_datrd);
        burst_q.push_back(mk(1'b0, waddr(6), '0, 4'h0));
        run_burst("abort_next");

        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(0, 9))
                0: r = mk_idle();
                1: r = mk($urandom_range(0, 1) == 1, BASE - 32'(4 * $urandom_range(1, 4)),
                          $urandom, 4'($urandom));
                default: begin
                    w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(248, 259);
                    r = mk($urandom_range(0, 1) == 1, waddr(w) + 32'($urandom_range(0, 3)),
                           $urandom, 4'($urandom));
                end
            endcase
            burst_q.push_back(r);
        end
        run_burst("random");

        // Classic instance: a held request is acked only every other cycle.
        bus_c.wb_cyc = 1'b1; bus_c.wb_stb = 1'b1; bus_c.wb_we = 1'b1;
        bus_c.wb_adr = 32'h8; bus_c.wb_datwr = 32'hC1A5_5C00; bus_c.wb_sel = 4'hF;
        step();
        check_eq("classic_wr.ack", 32'(bus_c.wb_ack), 32'h1);
        bus_c.wb_cyc = 1'b0; bus_c.wb_stb = 1'b0; bus_c.wb_we = 1'b0;
        step();
        check_eq("classic_idle.ack", 32'(bus_c.wb_ack), 32'h0);
        bus_c.wb_cyc = 1'b1; bus_c.wb_stb = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq($sformatf("classic_hold[%0d].ack", k), 32'(bus_c.wb_ack), 32'(k % 2));
            check_eq($sformatf("classic_hold[%0d].err", k), 32'(bus_c.wb_err), 32'h0);
            check_eq($sformatf("classic_hold[%0d].datrd", k), bus_c.wb_datrd, 32'hC1A5_5C00);
        end
        bus_c.wb_cyc = 1'b0; bus_c.wb_stb = 1'b0;
        step();
        check_eq("classic_end.ack", 32'(bus_c.wb_ack), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_sram_pipe.md
# wb_sram_pipe

Parametrised Wishbone SRAM slave: successor to the single-mode 32-bit SRAM slave. Supports configurable data width, depth and base address, classic or B4-pipelined handshaking, and an error response for out-of-range addresses. Sits on the Wishbone interconnect as an instruction/data memory for the core and for bench-loaded programs. Back-to-back transfers complete at one per cycle in pipelined mode.

## Interface
- addr_width, 32: Wishbone byte-address width.
- data_width, 32: data bus width; multiple of 8, 8 to 128.
- sel_width, data_width/8: byte-select width.
- depth, 256: number of data_width words; power of 2, at least 2.
- base_addr, 0: byte address of word 0; aligned to depth*sel_width.
- pipelined, 1: 1 = B4 pipelined handshake, 0 = classic handshake.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous reset, active-low: the block resets on a rising clock edge where reset==0.
- wb_adr  in  addr_width  byte address.
- wb_datwr  in  data_width  write data.
- wb_datrd  out  data_width  read data, valid with wb_ack on reads.
- wb_we  in  1  1 = write, 0 = read.
- wb_sel  in  sel_width  byte-lane enables; applied to writes only.
- wb_stb  in  1  strobe.
- wb_cyc  in  1  cycle.
- wb_ack  out  1  normal termination.
- wb_err  out  1  error termination (out-of-range).
- wb_stall  out  1  always 0; ports exist for B4 compliance.

## Operation
- Request: wb_cyc && wb_stb is sampled at a rising edge and the request is accepted.
  - Pipelined mode: accepted every such cycle.
  - Classic mode: accepted only when no response is pending (resp_q==0).
- Word index = (wb_adr - base_addr) >> log2(sel_width). The low log2(sel_width) address bits are ignored; there is no misalignment error.
- Out of range: wb_adr < base_addr, or index >= depth.
  - Request is accepted and answered with wb_err instead of wb_ack.
  - No memory write occurs and wb_datrd holds its previous value.
- Write, in range: for each lane i where wb_sel[i]==1, mem[index][8i+7:8i] <= wb_datwr[8i+7:8i] at the accept edge. Unselected lanes are unchanged. wb_sel==0 completes with ack and changes nothing.
- Read, in range: wb_datrd <= mem[index] at the accept edge. wb_datrd holds its value across writes, errors and idle cycles.
- Response register: resp_q in {IDLE, ACK, ERR} is loaded at each accept edge and returns to IDLE on any edge with no accept.
  - wb_ack = (resp_q==ACK) && wb_cyc.
  - wb_err = (resp_q==ERR) && wb_cyc.
  - If wb_cyc drops while a response is pending, that response is discarded: it is not output and not retried.
- Classic mode: a request held after its ack is not re-accepted in the ack cycle. The state sequence is IDLE→ACK→IDLE, so sustained throughput is one transfer per 2 cycles.
- Memory contents are not initialised or reset.
- Reset (reset==0 at an edge):
  - resp_q <= IDLE and wb_datrd <= 0.
  - A request present on that edge is dropped and no write occurs.
  - Outputs after reset: wb_ack=0, wb_err=0, wb_stall=0, wb_datrd=0.

## Timing
- Latency: response arrives exactly 1 cycle after the accept edge, in both modes.
- Pipelined: N consecutive requests produce N consecutive ack/err cycles, each offset by one cycle. No bubbles and no stall.
- Write-then-read to the same word in consecutive cycles: the read returns the newly written data.
- Read-then-write to the same word in consecutive cycles: the read returns the old data.
- Mixed ack/err streams preserve request order; there is exactly one response per accepted request.
- Address range: boundary word depth-1 is in range; depth wraps to err, never aliasing to word 0.
- Reset asserted with a response pending: the response is cleared at the reset edge and never appears.
- wb_stall is constant 0, including during reset.

## Test plan
- Reset: hold reset=0 for 2 cycles with stb/cyc=1, wb_we=1 to word 0, then release. Required: wb_ack=wb_err=wb_datrd=0, and a later read of word 0 shows no write from the reset cycles.
- Byte lanes (data_width=32, pipelined=1): write 0xFFFFFFFF to word 3, then write 0x12345678 with sel=4'b0101, then read word 3. Required: read data 0xFF34FF78 with ack 1 cycle after the read request.
- Back-to-back (pipelined=1): 4 consecutive requests: write 0xA5A5A5A5 to word 10, read 10, read 11, write word 11. Required: acks on 4 consecutive cycles, and the first read returns 0xA5A5A5A5.
- Range (depth=256, base_addr=0x1000): reads at 0x13FC and 0x1400, then a write at 0x0FFC. Required:
  - 0x13FC gets ack.
  - 0x1400 gets err with wb_datrd unchanged.
  - 0x0FFC gets err and memory is unchanged.
- Classic mode (pipelined=0): hold stb/cyc=1 for 6 cycles on reads. Required: ack on cycles 2, 4 and 6 only, and wb_err never asserts.
- Abort: accept a read, then drop wb_cyc the next cycle. Required: no ack appears; the next read is acked normally.
